// File: rtl/core_nios2_mulx_seq.sv
// ---------------------------------------------------------------------------
// core_nios2_mulx_seq
// Multicycle 32x32 multiply sequencer for the mul/mulx instruction path.
// The full 64-bit product is built from four 16x16 unsigned partial
// products. They pass through one registered multiplier and are summed in
// a 64-bit accumulator. A final step applies the signed high-word
// correction and returns either the low word (mul) or the high word (mulx*).
//
// Build option: CORE_MULX_SIGNED_EN
//   defined   -> MULXSU / MULXSS apply the signed correction.
//   undefined -> correction removed; ops 10/11 behave as MULXUU.
//
// Ports:
//   clk     in   core clock, rising edge
//   reset   in   asynchronous active-high reset
//   start   in   request, sampled only while ready=1
//   op      in   00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   src1    in   operand A (rA)
//   src2    in   operand B (rB)
//   ready   out  high in IDLE
//   busy    out  high in ISSUE/DRAIN/CORRECT
//   done    out  one-cycle pulse, result valid in the same cycle
//   result  out  registered result, held until the next done
// ---------------------------------------------------------------------------
module core_nios2_mulx_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned W_OP   = 32;
    localparam int unsigned W_HALF = 16;
    localparam int unsigned W_ACC  = 64;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    // Shift codes carried alongside each product
    localparam logic [1:0] SH_0  = 2'd0;
    localparam logic [1:0] SH_16 = 2'd1;
    localparam logic [1:0] SH_32 = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_DRAIN   = 3'd2,
        S_CORRECT = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e              state_q,    state_d;
    logic [W_OP-1:0]     a_q,        a_d;
    logic [W_OP-1:0]     b_q,        b_d;
    logic [1:0]          op_q,       op_d;
    logic [1:0]          k_q,        k_d;
    logic [W_ACC-1:0]    acc_q,      acc_d;
    logic [W_OP-1:0]     prod_q,     prod_d;
    logic                prod_vld_q, prod_vld_d;
    logic [1:0]          prod_sh_q,  prod_sh_d;
    logic [W_OP-1:0]     result_q,   result_d;

    logic [W_HALF-1:0]   mul_a_c;
    logic [W_HALF-1:0]   mul_b_c;
    logic [1:0]          sh_code_c;
    logic [W_ACC-1:0]    prod_ext_c;
    logic [W_OP-1:0]     hi_c;

    // Partial-operand select: k[0] picks a_hi, k[1] picks b_hi
    always_comb begin
        mul_a_c = k_q[0] ? a_q[31:16] : a_q[15:0];
        mul_b_c = k_q[1] ? b_q[31:16] : b_q[15:0];
        unique case (k_q)
            2'd0:    sh_code_c = SH_0;
            2'd3:    sh_code_c = SH_32;
            default: sh_code_c = SH_16;
        endcase
    end

    // Align the registered product for accumulation
    always_comb begin
        unique case (prod_sh_q)
            SH_16:   prod_ext_c = W_ACC'(prod_q) << 16;
            SH_32:   prod_ext_c = W_ACC'(prod_q) << 32;
            default: prod_ext_c = W_ACC'(prod_q);
        endcase
    end

    // High word with signed correction
`ifdef CORE_MULX_SIGNED_EN
    logic [W_OP-1:0] sub_a_neg_c;
    logic [W_OP-1:0] sub_b_neg_c;
    always_comb begin
        // op[1] set means src1 is treated as signed (MULXSU, MULXSS)
        sub_a_neg_c = (op_q[1] && a_q[31]) ? b_q : '0;
        sub_b_neg_c = ((op_q == OP_MULXSS) && b_q[31]) ? a_q : '0;
        hi_c        = acc_q[63:32] - sub_a_neg_c - sub_b_neg_c;
    end
`else
    always_comb begin
        hi_c = acc_q[63:32];
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        k_d        = k_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        prod_sh_d  = prod_sh_q;
        result_d   = result_q;

        // Product issued last cycle lands in the accumulator this cycle
        if (prod_vld_q) begin
            acc_d = acc_q + prod_ext_c;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = src1;
                    b_d     = src2;
                    op_d    = op;
                    acc_d   = '0;
                    k_d     = 2'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                prod_d     = W_OP'(mul_a_c) * W_OP'(mul_b_c);
                prod_vld_d = 1'b1;
                prod_sh_d  = sh_code_c;
                k_d        = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_CORRECT;
            end
            S_CORRECT: begin
                result_d = (op_q == OP_MUL) ? acc_q[31:0] : hi_c;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            prod_sh_q  <= SH_0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            prod_sh_q  <= prod_sh_d;
            result_q   <= result_d;
        end
    end

    // Handshake flags decoded from the state register
    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_CORRECT);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_core_nios2_mulx_seq.sv
// ---------------------------------------------------------------------------
// tb_core_nios2_mulx_seq
// Directed self-checking bench for core_nios2_mulx_seq. Each operation is
// followed cycle by cycle for the fixed 7-cycle latency plus one return
// cycle; handshake flags and the result are compared against hand-computed
// values. Expected signed results follow CORE_MULX_SIGNED_EN.
// ---------------------------------------------------------------------------
module tb_core_nios2_mulx_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int failures;

    core_nios2_mulx_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called in the cycle where start should be accepted (ready=1).
    // Leaves the bench in cycle T+8 so back-to-back calls are accepted.
    // glitch_j > 0 re-pulses start with different inputs during cycle T+glitch_j.
    task automatic do_op(input string tag, input logic [1:0] op_i,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int glitch_j);
        chk($sformatf("%s_ready_T0", tag), {31'b0, ready}, 32'd1);
        op    = op_i;
        src1  = a;
        src2  = b;
        start = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            src1  = ~a;
            src2  = ~b;
            op    = ~op_i;
            if (j == glitch_j) begin
                start = 1'b1;
            end
            chk($sformatf("%s_busy_T%0d", tag, j),  {31'b0, busy},  (j <= 6) ? 32'd1 : 32'd0);
            chk($sformatf("%s_done_T%0d", tag, j),  {31'b0, done},  (j == 7) ? 32'd1 : 32'd0);
            chk($sformatf("%s_ready_T%0d", tag, j), {31'b0, ready}, 32'd0);
        end
        chk($sformatf("%s_result_T7", tag), result, exp);
        @(posedge clk);
        #1;
        chk($sformatf("%s_ready_T8", tag),  {31'b0, ready}, 32'd1);
        chk($sformatf("%s_done_T8", tag),   {31'b0, done},  32'd0);
        chk($sformatf("%s_result_T8", tag), result, exp);
    endtask

    logic [31:0] exp_su_m1;
    logic [31:0] exp_ss_m1;
    logic [31:0] exp_ss_m2x3;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        src1     = '0;
        src2     = '0;

`ifdef CORE_MULX_SIGNED_EN
        exp_su_m1   = 32'hFFFF_FFFF;
        exp_ss_m1   = 32'h0000_0000;
        exp_ss_m2x3 = 32'hFFFF_FFFF;
`else
        exp_su_m1   = 32'hFFFF_FFFE;
        exp_ss_m1   = 32'hFFFF_FFFE;
        exp_ss_m2x3 = 32'h0000_0002;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  {31'b0, ready}, 32'd1);
        chk("rst_busy",   {31'b0, busy},  32'd0);
        chk("rst_done",   {31'b0, done},  32'd0);
        chk("rst_result", result, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_op("mul_a",       2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 0);
        do_op("mulxuu_a",    2'b01, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, 0);
        do_op("mulxuu_m1",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        do_op("mul_m1",      2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        do_op("mulxsu_m1",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_su_m1, 0);
        do_op("mulxss_m1",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_ss_m1, 0);
        do_op("mulxss_min",  2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        do_op("mulxss_m2x3", 2'b11, 32'hFFFF_FFFE, 32'h0000_0003, exp_ss_m2x3, 0);
        do_op("mulxsu_3xb",  2'b10, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0002, 0);

        // Start re-pulsed at T+3 is ignored; next op accepted at T+8
        do_op("mul_glitch",  2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3);
        do_op("mul_b2b",     2'b00, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F, 0);

        // Reset mid-operation
        op    = 2'b00;
        src1  = 32'h0001_0003;
        src2  = 32'h0002_0005;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_result", result, 32'h0);
        chk("abort_ready",  {31'b0, ready}, 32'd1);
        chk("abort_busy",   {31'b0, busy},  32'd0);
        chk("abort_done",   {31'b0, done},  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort_nodone_%0d", j), {31'b0, done}, 32'd0);
        end
        chk("abort_result_hold", result, 32'h0);
        do_op("mul_after_rst", 2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
